// File: rtl/decode_cycle.sv
// decode_cycle: RV32I decode stage with register file and ID/EX pipeline register.
//
// Decodes InstrD (lw, sw, R-type ALU, I-type ALU, beq) into control signals,
// reads two operands from a 32x32 register file and sign-extends the immediate.
// All results are registered into ID/EX and appear on the *E outputs one cycle later.
//
// Ports:
//   clk, rst                    clock (rising edge), asynchronous active-low reset
//   InstrD, PCD, PCPlus4D       instruction and its PCs from the fetch stage
//   RegWriteW, RDW, ResultW     register file write-back port from the W stage
//   FlushE                      load a bubble (all zeros) into ID/EX on the next edge
//   RegWriteE .. ALUControlE    registered control signals for EX
//   RD1_E, RD2_E, Imm_Ext_E     registered operands and immediate
//   RS1_E, RS2_E, RD_E          registered register indices (hazard unit)
//   PCE, PCPlus4E               registered PCs

module decode_cycle #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned NREGS = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [31:0]     InstrD,
    input  logic [XLEN-1:0] PCD,
    input  logic [XLEN-1:0] PCPlus4D,
    input  logic            RegWriteW,
    input  logic [4:0]      RDW,
    input  logic [XLEN-1:0] ResultW,
    input  logic            FlushE,
    output logic            RegWriteE,
    output logic            ResultSrcE,
    output logic            MemWriteE,
    output logic            BranchE,
    output logic            ALUSrcE,
    output logic [2:0]      ALUControlE,
    output logic [XLEN-1:0] RD1_E,
    output logic [XLEN-1:0] RD2_E,
    output logic [XLEN-1:0] Imm_Ext_E,
    output logic [4:0]      RS1_E,
    output logic [4:0]      RS2_E,
    output logic [4:0]      RD_E,
    output logic [XLEN-1:0] PCE,
    output logic [XLEN-1:0] PCPlus4E
);

    localparam logic [6:0] OpLoad  = 7'b0000011;
    localparam logic [6:0] OpStore = 7'b0100011;
    localparam logic [6:0] OpReg   = 7'b0110011;
    localparam logic [6:0] OpImm   = 7'b0010011;
    localparam logic [6:0] OpBeq   = 7'b1100011;

    localparam logic [2:0] AluAdd = 3'b000;
    localparam logic [2:0] AluSub = 3'b001;
    localparam logic [2:0] AluAnd = 3'b010;
    localparam logic [2:0] AluOr  = 3'b011;
    localparam logic [2:0] AluSlt = 3'b101;

    typedef enum logic [1:0] {ImmNone, ImmI, ImmS, ImmB} immSel_e;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [4:0] rs1, rs2, rd;

    assign opcode = InstrD[6:0];
    assign funct3 = InstrD[14:12];
    assign rs1    = InstrD[19:15];
    assign rs2    = InstrD[24:20];
    assign rd     = InstrD[11:7];

    // ---------------- register file ----------------
    // Entry 0 is never written; reads of x0 are also forced to zero below.
    logic [XLEN-1:0] regFile [NREGS];
    logic            wrEn;

    assign wrEn = RegWriteW && (RDW != 5'd0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(NREGS); i++) begin
                regFile[i] <= '0;
            end
        end else if (wrEn) begin
            regFile[RDW] <= ResultW;
        end
    end

    // Write-through: a same-cycle write-back to the register being read wins.
    logic [XLEN-1:0] rd1D, rd2D;

    always_comb begin
        rd1D = '0;
        rd2D = '0;
        if (rs1 != 5'd0) rd1D = (wrEn && RDW == rs1) ? ResultW : regFile[rs1];
        if (rs2 != 5'd0) rd2D = (wrEn && RDW == rs2) ? ResultW : regFile[rs2];
    end

    // ---------------- control decode ----------------
    logic       regWriteD, resultSrcD, memWriteD, branchD, aluSrcD;
    logic [2:0] aluCtrlD;
    immSel_e    immSel;
    logic       aluValid;
    logic [2:0] aluOp;

    // funct3 map shared by R-type and I-ALU; funct7[5] selects sub only for R-type.
    always_comb begin
        aluValid = 1'b1;
        aluOp    = AluAdd;
        case (funct3)
            3'b000:  aluOp = (opcode == OpReg && InstrD[30]) ? AluSub : AluAdd;
            3'b010:  aluOp = AluSlt;
            3'b110:  aluOp = AluOr;
            3'b111:  aluOp = AluAnd;
            default: aluValid = 1'b0;
        endcase
    end

    always_comb begin
        regWriteD  = 1'b0;
        resultSrcD = 1'b0;
        memWriteD  = 1'b0;
        branchD    = 1'b0;
        aluSrcD    = 1'b0;
        aluCtrlD   = AluAdd;
        immSel     = ImmNone;
        case (opcode)
            OpLoad: begin
                regWriteD  = 1'b1;
                resultSrcD = 1'b1;
                aluSrcD    = 1'b1;
                immSel     = ImmI;
            end
            OpStore: begin
                memWriteD = 1'b1;
                aluSrcD   = 1'b1;
                immSel    = ImmS;
            end
            OpReg: begin
                if (aluValid) begin
                    regWriteD = 1'b1;
                    aluCtrlD  = aluOp;
                end
            end
            OpImm: begin
                if (aluValid) begin
                    regWriteD = 1'b1;
                    aluSrcD   = 1'b1;
                    aluCtrlD  = aluOp;
                    immSel    = ImmI;
                end
            end
            OpBeq: begin
                branchD  = 1'b1;
                aluCtrlD = AluSub;
                immSel   = ImmB;
            end
            default: ;
        endcase
    end

    // ---------------- immediate extension ----------------
    logic [XLEN-1:0] immD;

    always_comb begin
        immD = '0;
        case (immSel)
            ImmI:    immD = {{(XLEN-12){InstrD[31]}}, InstrD[31:20]};
            ImmS:    immD = {{(XLEN-12){InstrD[31]}}, InstrD[31:25], InstrD[11:7]};
            ImmB:    immD = {{(XLEN-13){InstrD[31]}}, InstrD[31], InstrD[7],
                             InstrD[30:25], InstrD[11:8], 1'b0};
            default: immD = '0;
        endcase
    end

    // ---------------- ID/EX pipeline register ----------------
    // Async reset clears every field, so all outputs drop to 0 as soon as rst falls.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst || FlushE) begin
            if (!rst) begin
                RegWriteE <= 1'b0;
            end else begin
                RegWriteE <= 1'b0;
            end
            ResultSrcE  <= 1'b0;
            MemWriteE   <= 1'b0;
            BranchE     <= 1'b0;
            ALUSrcE     <= 1'b0;
            ALUControlE <= '0;
            RD1_E       <= '0;
            RD2_E       <= '0;
            Imm_Ext_E   <= '0;
            RS1_E       <= '0;
            RS2_E       <= '0;
            RD_E        <= '0;
            PCE         <= '0;
            PCPlus4E    <= '0;
        end else begin
            RegWriteE   <= regWriteD;
            ResultSrcE  <= resultSrcD;
            MemWriteE   <= memWriteD;
            BranchE     <= branchD;
            ALUSrcE     <= aluSrcD;
            ALUControlE <= aluCtrlD;
            RD1_E       <= rd1D;
            RD2_E       <= rd2D;
            Imm_Ext_E   <= immD;
            RS1_E       <= rs1;
            RS2_E       <= rs2;
            RD_E        <= rd;
            PCE         <= PCD;
            PCPlus4E    <= PCPlus4D;
        end
    end

endmodule

// File: tb/tb_decode_cycle.sv
// Directed self-checking bench for decode_cycle.
module tb_decode_cycle;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] InstrD, PCD, PCPlus4D, ResultW;
    logic        RegWriteW, FlushE;
    logic [4:0]  RDW;
    logic        RegWriteE, ResultSrcE, MemWriteE, BranchE, ALUSrcE;
    logic [2:0]  ALUControlE;
    logic [31:0] RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E;
    logic [4:0]  RS1_E, RS2_E, RD_E;

    int passCount = 0;
    int totalCount = 0;

    decode_cycle dut (
        .clk(clk), .rst(rst), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D),
        .RegWriteW(RegWriteW), .RDW(RDW), .ResultW(ResultW), .FlushE(FlushE),
        .RegWriteE(RegWriteE), .ResultSrcE(ResultSrcE), .MemWriteE(MemWriteE),
        .BranchE(BranchE), .ALUSrcE(ALUSrcE), .ALUControlE(ALUControlE),
        .RD1_E(RD1_E), .RD2_E(RD2_E), .Imm_Ext_E(Imm_Ext_E), .RS1_E(RS1_E),
        .RS2_E(RS2_E), .RD_E(RD_E), .PCE(PCE), .PCPlus4E(PCPlus4E)
    );

    always #5 clk = ~clk;

    // {RegWrite, ResultSrc, MemWrite, Branch, ALUSrc, ALUControl}
    logic [7:0] ctrl;
    assign ctrl = {RegWriteE, ResultSrcE, MemWriteE, BranchE, ALUSrcE, ALUControlE};

    logic anyOut;
    assign anyOut = |{ctrl, RD1_E, RD2_E, Imm_Ext_E, RS1_E, RS2_E, RD_E, PCE, PCPlus4E};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        totalCount++;
        assert (obs === exp) passCount++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset with arbitrary inputs, including a write-back that must not land.
        rst = 1'b0; InstrD = 32'h00028333; PCD = 32'h100; PCPlus4D = 32'h104;
        RegWriteW = 1'b1; RDW = 5'd3; ResultW = 32'hAAAA5555; FlushE = 1'b0;
        tick(); tick();
        chk("reset_all_zero", {31'd0, anyOut}, 32'd0);

        @(negedge clk);
        rst = 1'b1; RegWriteW = 1'b0; InstrD = 32'h00000013; PCD = 32'h40; PCPlus4D = 32'h44;
        tick();
        chk("addi_ctrl", {24'd0, ctrl}, 32'h88);
        chk("addi_rd", {27'd0, RD_E}, 32'd0);
        chk("addi_imm", Imm_Ext_E, 32'd0);
        chk("addi_pce", PCE, 32'h40);
        chk("addi_pcp4e", PCPlus4E, 32'h44);

        // Write x5 while decoding an illegal opcode.
        InstrD = 32'hFFFFFFFF; RegWriteW = 1'b1; RDW = 5'd5; ResultW = 32'hDEADBEEF;
        tick();
        chk("illegal_ctrl", {24'd0, ctrl}, 32'h00);
        chk("illegal_imm", Imm_Ext_E, 32'd0);

        RegWriteW = 1'b0; InstrD = 32'h00028333;          // add x6,x5,x0
        tick();
        chk("add_rd1", RD1_E, 32'hDEADBEEF);
        chk("add_rd2", RD2_E, 32'd0);
        chk("add_ctrl", {24'd0, ctrl}, 32'h80);
        chk("add_rd", {27'd0, RD_E}, 32'd6);
        chk("add_rs1", {27'd0, RS1_E}, 32'd5);

        // Write-through: write x7 and read it in the same cycle.
        RegWriteW = 1'b1; RDW = 5'd7; ResultW = 32'h12345678; InstrD = 32'h407380B3;
        tick();
        chk("wt_rd1", RD1_E, 32'h12345678);
        chk("wt_rd2", RD2_E, 32'h12345678);
        chk("sub_ctrl", {24'd0, ctrl}, 32'h81);
        chk("sub_rd", {27'd0, RD_E}, 32'd1);

        // x0 protection, including no write-through for x0.
        RegWriteW = 1'b1; RDW = 5'd0; ResultW = 32'hFFFFFFFF; InstrD = 32'h00000333;
        tick();
        chk("x0_wt_rd1", RD1_E, 32'd0);
        RegWriteW = 1'b0; InstrD = 32'h00000333;
        tick();
        chk("x0_rd1", RD1_E, 32'd0);
        InstrD = 32'h00018333;                            // add x6,x3,x0
        tick();
        chk("x3_untouched", RD1_E, 32'd0);
        InstrD = 32'h00538333;                            // add x6,x7,x5
        tick();
        chk("persist_rd1", RD1_E, 32'h12345678);
        chk("persist_rd2", RD2_E, 32'hDEADBEEF);

        InstrD = 32'hFFC0A103;                            // lw x2,-4(x1)
        tick();
        chk("lw_imm", Imm_Ext_E, 32'hFFFFFFFC);
        chk("lw_ctrl", {24'd0, ctrl}, 32'hC8);
        chk("lw_rd", {27'd0, RD_E}, 32'd2);

        InstrD = 32'h0020A423;                            // sw x2,8(x1)
        tick();
        chk("sw_imm", Imm_Ext_E, 32'd8);
        chk("sw_ctrl", {24'd0, ctrl}, 32'h28);
        chk("sw_rs2", {27'd0, RS2_E}, 32'd2);

        InstrD = 32'hFE208CE3;                            // beq x1,x2,-8
        tick();
        chk("beq_imm", Imm_Ext_E, 32'hFFFFFFF8);
        chk("beq_ctrl", {24'd0, ctrl}, 32'h11);

        InstrD = 32'hFFF3E213;                            // ori x4,x7,-1
        tick();
        chk("ori_ctrl", {24'd0, ctrl}, 32'h8B);
        chk("ori_imm", Imm_Ext_E, 32'hFFFFFFFF);
        chk("ori_rd1", RD1_E, 32'h12345678);

        InstrD = 32'h40000213;                            // addi x4,x0,0x400 (bit30 set)
        tick();
        chk("addi_b30_ctrl", {24'd0, ctrl}, 32'h88);
        chk("addi_b30_imm", Imm_Ext_E, 32'h400);

        InstrD = 32'h0072A233;                            // slt x4,x5,x7
        tick();
        chk("slt_ctrl", {24'd0, ctrl}, 32'h85);
        InstrD = 32'h0072F233;                            // and x4,x5,x7
        tick();
        chk("and_ctrl", {24'd0, ctrl}, 32'h82);
        InstrD = 32'h00729233;                            // sll: unsupported funct3
        tick();
        chk("badf3_ctrl", {24'd0, ctrl}, 32'h00);
        chk("badf3_imm", Imm_Ext_E, 32'd0);

        // Flush with simultaneous write-back: write lands, ID/EX is a bubble.
        FlushE = 1'b1; InstrD = 32'h00538333; PCD = 32'h80; PCPlus4D = 32'h84;
        RegWriteW = 1'b1; RDW = 5'd9; ResultW = 32'hCAFEF00D;
        tick();
        chk("flush_all_zero", {31'd0, anyOut}, 32'd0);
        FlushE = 1'b0; RegWriteW = 1'b0; InstrD = 32'h00048333;   // add x6,x9,x0
        tick();
        chk("flush_wb_rd1", RD1_E, 32'hCAFEF00D);
        chk("flush_wb_pce", PCE, 32'h80);

        // Asynchronous reset mid-operation, away from any clock edge.
        #2;
        rst = 1'b0;
        #1;
        chk("async_rst_zero", {31'd0, anyOut}, 32'd0);
        @(negedge clk);
        rst = 1'b1; InstrD = 32'h00538333;
        tick();
        chk("post_rst_rd1", RD1_E, 32'd0);
        chk("post_rst_rd2", RD2_E, 32'd0);
        chk("post_rst_ctrl", {24'd0, ctrl}, 32'h80);

        $display("%0d/%0d checks passed", passCount, totalCount);
        $finish;
    end

endmodule
